// File: rtl/apb_master_ctrl_if.sv
// Request/APB/response bundle between the AHB front-end, the APB master
// controller and the APB peripherals.
//   master : controller view (drives req_ready, APB outputs, response, busy)
//   slave  : front-end / peripheral view (drives request fields and prdata)
interface apb_master_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        pwrite;
    logic        penable;
    logic [2:0]  psel;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, prdata,
        output req_ready, pwrite, penable, psel, paddr, pwdata,
        output rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, prdata,
        input  req_ready, pwrite, penable, psel, paddr, pwdata,
        input  rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB-side master controller of the AHB-to-APB bridge.
// Buffers one request from the front-end, decodes the target peripheral,
// runs the APB SETUP/ACCESS sequence and returns a one-cycle response pulse.
// Ports:
//   hclk   : bridge clock, rising edge
//   hreset : asynchronous active-high reset
//   bus    : apb_master_ctrl_if.master (request handshake, APB bundle,
//            response and busy); all outputs are registered.
module apb_master_ctrl #(
    parameter logic [3:0] DECODE_TAG = 4'h8
) (
    input  logic                  hclk,
    input  logic                  hreset,
    apb_master_ctrl_if.master     bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    // Returns {error, psel}; an unmatched tag or region 11 is an error.
    function automatic logic [3:0] decode_target(input logic [31:0] addr);
        logic [3:0] res;
        if (addr[31:28] != DECODE_TAG) begin
            res = {1'b1, 3'b000};
        end else begin
            case (addr[27:26])
                2'b00:   res = {1'b0, 3'b001};
                2'b01:   res = {1'b0, 3'b010};
                2'b10:   res = {1'b0, 3'b100};
                2'b11:   res = {1'b1, 3'b000};
                default: res = {1'b1, 3'b000};
            endcase
        end
        return res;
    endfunction

    state_t      state_r;
    logic        hold_full_r;
    logic        hold_write_r;
    logic [31:0] hold_addr_r;
    logic [31:0] hold_wdata_r;
    logic        req_ready_r;
    logic        busy_r;
    logic        pwrite_r;
    logic        penable_r;
    logic [2:0]  psel_r;
    logic [31:0] paddr_r;
    logic [31:0] pwdata_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;

    logic        accept_s;
    logic        pop_s;
    logic        hold_full_nxt_s;
    logic        dec_err_s;
    logic [2:0]  dec_psel_s;

    // Handshake, pop and decode of the buffered request.
    always_comb begin
        accept_s        = 1'b0;
        pop_s           = 1'b0;
        hold_full_nxt_s = hold_full_r;
        {dec_err_s, dec_psel_s} = decode_target(hold_addr_r);
        accept_s = bus.req_valid && !hold_full_r;
        // Any state other than SETUP is a point where the next request may start.
        if (state_r != ST_SETUP) begin
            pop_s = hold_full_r;
        end else begin
            pop_s = 1'b0;
        end
        // Accept only happens while empty and pop only while full, so they never collide.
        if (accept_s) begin
            hold_full_nxt_s = 1'b1;
        end else if (pop_s) begin
            hold_full_nxt_s = 1'b0;
        end else begin
            hold_full_nxt_s = hold_full_r;
        end
    end

    // Holding register, transfer FSM and all registered outputs.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_r      <= ST_IDLE;
            hold_full_r  <= 1'b0;
            hold_write_r <= 1'b0;
            hold_addr_r  <= 32'h0000_0000;
            hold_wdata_r <= 32'h0000_0000;
            req_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            pwrite_r     <= 1'b0;
            penable_r    <= 1'b0;
            psel_r       <= 3'b000;
            paddr_r      <= 32'h0000_0000;
            pwdata_r     <= 32'h0000_0000;
            rsp_valid_r  <= 1'b0;
            rsp_rdata_r  <= 32'h0000_0000;
            rsp_err_r    <= 1'b0;
        end else begin
            hold_full_r <= hold_full_nxt_s;
            if (accept_s) begin
                hold_write_r <= bus.req_write;
                hold_addr_r  <= bus.req_addr;
                hold_wdata_r <= bus.req_wdata;
            end
            req_ready_r <= !hold_full_nxt_s;
            // FSM leaves IDLE next cycle iff it pops now or is mid-transfer in SETUP.
            busy_r      <= hold_full_nxt_s || pop_s || (state_r == ST_SETUP);

            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;

            case (state_r)
                ST_SETUP: begin
                    state_r   <= ST_ACCESS;
                    penable_r <= 1'b1;
                end
                ST_IDLE, ST_ACCESS, ST_ERR: begin
                    if (state_r == ST_ACCESS) begin
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= pwrite_r ? 32'h0000_0000 : bus.prdata;
                    end else if (state_r == ST_ERR) begin
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                    end
                    penable_r <= 1'b0;
                    if (pop_s && !dec_err_s) begin
                        state_r  <= ST_SETUP;
                        psel_r   <= dec_psel_s;
                        pwrite_r <= hold_write_r;
                        paddr_r  <= hold_addr_r;
                        pwdata_r <= hold_write_r ? hold_wdata_r : 32'h0000_0000;
                    end else begin
                        state_r  <= pop_s ? ST_ERR : ST_IDLE;
                        psel_r   <= 3'b000;
                        pwrite_r <= 1'b0;
                        paddr_r  <= 32'h0000_0000;
                        pwdata_r <= 32'h0000_0000;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    penable_r <= 1'b0;
                    psel_r    <= 3'b000;
                    pwrite_r  <= 1'b0;
                    paddr_r   <= 32'h0000_0000;
                    pwdata_r  <= 32'h0000_0000;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.busy      = busy_r;
    assign bus.pwrite    = pwrite_r;
    assign bus.penable   = penable_r;
    assign bus.psel      = psel_r;
    assign bus.paddr     = paddr_r;
    assign bus.pwdata    = pwdata_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed self-checking bench for apb_master_ctrl.
module tb_apb_master_ctrl;

    logic        hclk;
    logic        hreset;
    logic [31:0] rd_val;
    int          n_total;
    int          n_pass;

    apb_master_ctrl_if bus ();

    apb_master_ctrl #(.DECODE_TAG(4'h8)) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Peripheral model: returns rd_val only during a read ACCESS, junk otherwise.
    always_comb begin
        bus.prdata = (bus.penable && !bus.pwrite) ? rd_val : 32'hA5A5_A5A5;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    // Offer one request for exactly one edge (caller ensures req_ready=1).
    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rd_val  = 32'h0;
        hreset  = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        step();
        step();
        hreset = 1'b0;
        step();
        chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);

        // Reset asserted mid-cycle while a request is in SETUP and req_valid is high.
        send(1'b1, 32'h8000_0010, 32'h1111_2222);
        bus.req_valid = 1'b1;
        step();
        chk("pre_rst_psel", {29'd0, bus.psel}, 32'd1);
        #2;
        hreset = 1'b1;
        #1;
        chk("rst_async_psel", {29'd0, bus.psel}, 32'd0);
        chk("rst_async_paddr", bus.paddr, 32'h0);
        chk("rst_async_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_async_busy", {31'd0, bus.busy}, 32'd0);
        step();
        step();
        chk("rst_no_accept", {31'd0, bus.busy}, 32'd0);
        chk("rst_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        bus.req_valid = 1'b0;
        hreset = 1'b0;
        step();
        chk("rst_rel_busy", {31'd0, bus.busy}, 32'd0);

        // Single write.
        send(1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
        chk("wr_ready_full", {31'd0, bus.req_ready}, 32'd0);
        chk("wr_busy", {31'd0, bus.busy}, 32'd1);
        step();
        chk("wr_setup_psel", {29'd0, bus.psel}, 32'd1);
        chk("wr_setup_pwrite", {31'd0, bus.pwrite}, 32'd1);
        chk("wr_setup_penable", {31'd0, bus.penable}, 32'd0);
        chk("wr_setup_paddr", bus.paddr, 32'h8000_0010);
        chk("wr_setup_pwdata", bus.pwdata, 32'hDEAD_BEEF);
        step();
        chk("wr_access_penable", {31'd0, bus.penable}, 32'd1);
        chk("wr_access_psel", {29'd0, bus.psel}, 32'd1);
        chk("wr_access_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        step();
        chk("wr_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("wr_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("wr_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("wr_idle_psel", {29'd0, bus.psel}, 32'd0);
        chk("wr_idle_penable", {31'd0, bus.penable}, 32'd0);
        chk("wr_idle_paddr", bus.paddr, 32'h0);
        chk("wr_idle_pwdata", bus.pwdata, 32'h0);
        chk("wr_idle_pwrite", {31'd0, bus.pwrite}, 32'd0);
        chk("wr_idle_busy", {31'd0, bus.busy}, 32'd0);
        step();
        chk("wr_rsp_pulse", {31'd0, bus.rsp_valid}, 32'd0);

        // Single read.
        rd_val = 32'h0000_005A;
        send(1'b0, 32'h8400_0004, 32'h1111_1111);
        step();
        chk("rd_setup_psel", {29'd0, bus.psel}, 32'd2);
        chk("rd_setup_pwrite", {31'd0, bus.pwrite}, 32'd0);
        chk("rd_setup_pwdata", bus.pwdata, 32'h0);
        chk("rd_setup_paddr", bus.paddr, 32'h8400_0004);
        step();
        chk("rd_access_penable", {31'd0, bus.penable}, 32'd1);
        step();
        chk("rd_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("rd_rsp_rdata", bus.rsp_rdata, 32'h0000_005A);
        chk("rd_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        step();

        // Back-to-back: second request offered during the first SETUP.
        rd_val = 32'h0000_0077;
        send(1'b1, 32'h8800_0000, 32'hCAFE_F00D);
        step();
        chk("b2b_setup1_psel", {29'd0, bus.psel}, 32'd4);
        chk("b2b_setup1_ready", {31'd0, bus.req_ready}, 32'd1);
        send(1'b0, 32'h8000_0008, 32'h0);
        chk("b2b_access1_penable", {31'd0, bus.penable}, 32'd1);
        chk("b2b_access1_psel", {29'd0, bus.psel}, 32'd4);
        chk("b2b_access1_ready", {31'd0, bus.req_ready}, 32'd0);
        step();
        chk("b2b_setup2_psel", {29'd0, bus.psel}, 32'd1);
        chk("b2b_setup2_penable", {31'd0, bus.penable}, 32'd0);
        chk("b2b_setup2_paddr", bus.paddr, 32'h8000_0008);
        chk("b2b_rsp1_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("b2b_rsp1_rdata", bus.rsp_rdata, 32'h0);
        step();
        chk("b2b_access2_penable", {31'd0, bus.penable}, 32'd1);
        chk("b2b_gap_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        step();
        chk("b2b_rsp2_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("b2b_rsp2_rdata", bus.rsp_rdata, 32'h0000_0077);
        chk("b2b_end_busy", {31'd0, bus.busy}, 32'd0);
        step();

        // Tag mismatch.
        send(1'b0, 32'h9000_0000, 32'h0);
        step();
        chk("err1_psel", {29'd0, bus.psel}, 32'd0);
        chk("err1_penable", {31'd0, bus.penable}, 32'd0);
        chk("err1_early_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        chk("err1_busy", {31'd0, bus.busy}, 32'd1);
        step();
        chk("err1_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("err1_rsp_err", {31'd0, bus.rsp_err}, 32'd1);
        chk("err1_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("err1_psel_after", {29'd0, bus.psel}, 32'd0);
        step();

        // Region 11 under a matching tag.
        send(1'b1, 32'h8C00_0000, 32'h5555_AAAA);
        step();
        chk("err2_psel", {29'd0, bus.psel}, 32'd0);
        chk("err2_pwdata", bus.pwdata, 32'h0);
        step();
        chk("err2_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("err2_rsp_err", {31'd0, bus.rsp_err}, 32'd1);
        chk("err2_penable", {31'd0, bus.penable}, 32'd0);
        step();

        // Reset during ACCESS with a second request buffered.
        send(1'b1, 32'h8000_0020, 32'h0000_0001);
        step();
        send(1'b0, 32'h8400_0000, 32'h0);
        chk("rstacc_penable", {31'd0, bus.penable}, 32'd1);
        chk("rstacc_full", {31'd0, bus.req_ready}, 32'd0);
        #2;
        hreset = 1'b1;
        #1;
        chk("rstacc_penable0", {31'd0, bus.penable}, 32'd0);
        chk("rstacc_psel0", {29'd0, bus.psel}, 32'd0);
        chk("rstacc_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rstacc_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        step();
        hreset = 1'b0;
        step();
        chk("rstacc_rel_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rstacc_rel_busy", {31'd0, bus.busy}, 32'd0);
        step();
        chk("rstacc_rel_rsp2", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rstacc_rel_psel", {29'd0, bus.psel}, 32'd0);

        rd_val = 32'h1234_5678;
        send(1'b0, 32'h8000_0000, 32'h0);
        step();
        chk("post_setup_psel", {29'd0, bus.psel}, 32'd1);
        step();
        chk("post_access_penable", {31'd0, bus.penable}, 32'd1);
        step();
        chk("post_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("post_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
        chk("post_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        step();
        chk("post_rsp_pulse", {31'd0, bus.rsp_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/apb_master_ctrl.md
# apb_master_ctrl

APB-side master controller of the AHB-to-APB bridge. It accepts single 32-bit read/write requests from the AHB slave front-end through a valid/ready handshake and buffers one request. It decodes the target peripheral, then runs the APB SETUP/ACCESS sequence, driving the same pwrite/penable/psel/paddr/pwdata bundle the APB peripheral interface consumes. It returns read data or an error response to the front-end.

## Interface

Parameters:
- DECODE_TAG, 4'h8, required value of address bits [31:28] for any valid peripheral access

Ports:
- hclk  in  1  bridge clock; all state changes on rising edge
- hreset  in  1  asynchronous, active-high reset
- req_valid  in  1  front-end request present
- req_ready  out  1  controller can accept a request this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- pwrite  out  1  APB write strobe
- penable  out  1  APB enable (ACCESS phase)
- psel  out  3  one-hot APB peripheral select
- paddr  out  32  APB address
- pwdata  out  32  APB write data
- prdata  in  32  APB read data, valid while penable=1 and pwrite=0
- rsp_valid  out  1  one-cycle response pulse per accepted request
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  decode error, qualified by rsp_valid
- busy  out  1  holding register full or FSM not IDLE

## Operation

- One-entry holding register (hold_full, write, addr, wdata).
  - req_ready = !hold_full.
  - req_valid && req_ready at a rising edge loads it and sets hold_full.
- Decode at pop:
  - addr[31:28] == DECODE_TAG required.
  - addr[27:26]: 00 -> psel 3'b001, 01 -> 3'b010, 10 -> 3'b100, 11 -> error.
  - Any tag mismatch is an error.
- FSM states: IDLE, SETUP, ACCESS, ERR.
  - IDLE: if hold_full, pop. Valid decode -> SETUP; error -> ERR. Otherwise stay in IDLE.
  - SETUP: psel=decoded, penable=0, paddr/pwrite loaded. pwdata = wdata for writes, 0 for reads. Always -> ACCESS.
  - ACCESS: penable=1, all other APB outputs held. No pready: ACCESS is exactly one cycle. Exit is the same as IDLE: pop if hold_full, else IDLE.
  - ERR: no APB activity (psel=0, penable=0). Exit is the same as IDLE.
- Popping clears hold_full in that edge, so a new request can be accepted during SETUP.
- Response:
  - At the edge leaving ACCESS, rsp_valid<=1.
  - rsp_rdata <= prdata for reads, 0 for writes; rsp_err<=0.
  - At the edge leaving ERR, rsp_valid<=1, rsp_err<=1, rsp_rdata<=0.
  - rsp_valid is a single-cycle pulse; there is no backpressure on the response.
- Leaving to IDLE: psel, penable, pwrite, paddr and pwdata return to 0.
- Back-to-back (ACCESS -> SETUP): psel changes to the new target and penable drops to 0.
- Exactly one response per accepted request, in acceptance order.

## Timing

- Reset (asynchronous, immediate):
  - Outputs: req_ready=1, busy=0, and pwrite, penable, psel, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err all 0.
  - State: FSM=IDLE, hold_full=0.
- Single request accepted at edge E0 (hold_full=1 from E0):
  - E1: enter SETUP.
  - E2: enter ACCESS.
  - E3: rsp_valid high for the cycle after E3.
  - Latency is 3 edges from acceptance to response.
- Decode error accepted at E0: ERR from E1, rsp_valid/rsp_err after E2.
- Sustained throughput: one APB transfer per 2 cycles.
- Simultaneous pop and new request: req_ready is 0 while full, so there is no same-cycle refill. A request offered while full waits, and req_* must be held stable by the front-end.
- Reset asserted mid-SETUP/ACCESS/ERR:
  - The transfer is abandoned and the buffered request is dropped.
  - No response is issued; all outputs return to reset values at once.
- All outputs are registered; nothing combinational from prdata to any output.

## Test plan

- Reset: assert hreset mid-cycle with req_valid=1 -> all outputs 0 and req_ready=1 immediately; no acceptance while reset is high.
- Write 0xDEADBEEF to 0x8000_0010:
  - SETUP: psel=001, pwrite=1, penable=0, paddr=0x8000_0010, pwdata=0xDEADBEEF.
  - Next cycle: penable=1.
  - Then rsp_valid=1, rsp_rdata=0, rsp_err=0; APB outputs return to 0.
- Read 0x8400_0004 with the model driving prdata=0x0000_005A during ACCESS -> psel=010, pwrite=0, pwdata=0, then rsp_rdata=0x5A.
- Back-to-back: write 0x8800_0000, then read 0x8000_0008 offered during SETUP of the first:
  - Second SETUP directly follows first ACCESS, psel 100 -> 001, penable 1 -> 0.
  - Two rsp_valid pulses 2 cycles apart.
- Errors: requests to 0x9000_0000 and 0x8C00_0000 -> psel/penable never asserted; rsp_valid=1 with rsp_err=1, rsp_rdata=0, 2 edges after acceptance.
- Reset during ACCESS with a second request buffered -> no rsp_valid for either; after release, a new read to 0x8000_0000 completes normally.
